// File: rtl/count_run_ctrl.sv
// Front-end control for the two-digit BCD counter: debounced RUN/LOAD buttons,
// RUN/PAUSE/LOAD sequencing, count-enable tick generation and validated BCD preset.
module count_run_ctrl #(
  parameter int CLK_HZ          = 100_000_000,
  parameter int TICK_HZ         = 1,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_run,
  input  logic       btn_load,
  input  logic [3:0] sw_val,
  output logic       tick_o,
  output logic       load_o,
  output logic [3:0] load_val,
  output logic       load_err,
  output logic       running
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int DIV_W = $clog2(DIV);
  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]       BCD_MAX  = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_LOAD
  } state_t;

  // Reset asserts asynchronously but releases on a clock edge, so no flop
  // sees reset removal close to its sampling point.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_sync <= '0;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  // Index 0 is the RUN button, index 1 the LOAD button.
  logic [1:0]      w_btn;
  logic [1:0]      r_meta;
  logic [1:0]      r_sync;
  logic [1:0]      r_db;
  logic [1:0]      r_db_q;
  logic [1:0]      r_press;
  logic [DB_W-1:0] r_db_cnt [2];

  assign w_btn = {btn_load, btn_run};

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_meta   <= '0;
      r_sync   <= '0;
      r_db     <= '0;
      r_db_q   <= '0;
      r_press  <= '0;
      r_db_cnt <= '{default: '0};
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of its neighbours, as the hardware does.
      r_meta <= w_btn;
      r_sync <= r_meta;
      r_db_q <= r_db;
      for (int i = 0; i < 2; i++) begin
        // Any reversal while a change is pending restarts the stability count.
        if (r_sync[i] != r_db[i]) begin
          if (r_db_cnt[i] == DB_LAST) begin
            r_db[i]     <= r_sync[i];
            r_db_cnt[i] <= '0;
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
        r_press[i] <= r_db[i] & ~r_db_q[i];
      end
    end
  end

  logic w_run_p;
  logic w_load_p;

  assign w_run_p  = r_press[0];
  assign w_load_p = r_press[1];

  state_t           r_state;
  logic [DIV_W-1:0] r_div;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state  <= S_IDLE;
      r_div    <= '0;
      tick_o   <= 1'b0;
      load_o   <= 1'b0;
      load_err <= 1'b0;
      load_val <= '0;
      running  <= 1'b0;
    end else begin
      tick_o   <= 1'b0;
      load_o   <= 1'b0;
      load_err <= 1'b0;
      running  <= (r_state == S_RUN);
      case (r_state)
        S_IDLE: begin
          r_div <= '0;
          if (w_load_p) begin
            r_state <= S_LOAD;
          end else if (w_run_p) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_div == DIV_LAST) begin
            r_div  <= '0;
            tick_o <= 1'b1;
          end else begin
            r_div <= r_div + 1'b1;
          end
          if (w_load_p) begin
            r_state <= S_LOAD;
          end else if (w_run_p) begin
            r_state <= S_PAUSE;
          end
        end
        S_PAUSE: begin
          // Divider holds so a resume continues the interrupted tick period.
          if (w_load_p) begin
            r_state <= S_LOAD;
          end else if (w_run_p) begin
            r_state <= S_RUN;
          end
        end
        S_LOAD: begin
          r_div    <= '0;
          load_o   <= 1'b1;
          load_err <= (sw_val > BCD_MAX);
          load_val <= (sw_val <= BCD_MAX) ? sw_val : 4'd0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_div   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_run_ctrl.sv
// Directed bench for count_run_ctrl with DIV=10 and DEBOUNCE_CYCLES=4; outputs are
// sampled on the falling clock edge and compared against hand-computed values.
module tb_count_run_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_run;
  logic       btn_load;
  logic [3:0] sw_val;
  logic       tick_o;
  logic       load_o;
  logic [3:0] load_val;
  logic       load_err;
  logic       running;

  always #5 clk = ~clk;

  count_run_ctrl #(
    .CLK_HZ         (100),
    .TICK_HZ        (10),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_run (btn_run),
    .btn_load(btn_load),
    .sw_val  (sw_val),
    .tick_o  (tick_o),
    .load_o  (load_o),
    .load_val(load_val),
    .load_err(load_err),
    .running (running)
  );

  int         n_vec    = 0;
  int         n_err    = 0;
  int         tick_cnt = 0;
  int         load_cnt = 0;
  int         run_cnt  = 0;
  int         both_cnt = 0;
  int         gaps[$];
  logic [3:0] last_val = '0;
  logic       last_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n cycles, sampling outputs at each falling edge. run_cnt counts
  // running-high cycles since the last tick; a kept phase makes every gap 10.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      if (tick_o && load_o) both_cnt++;
      if (running) run_cnt++;
      if (tick_o) begin
        tick_cnt++;
        gaps.push_back(run_cnt);
        run_cnt = 0;
      end
      if (load_o) begin
        load_cnt++;
        last_val = load_val;
        last_err = load_err;
        run_cnt  = 0;
      end
    end
  endtask

  task automatic press(input logic do_run, input logic do_load);
    btn_run  = do_run;
    btn_load = do_load;
    step(12);
    btn_run  = 1'b0;
    btn_load = 1'b0;
    step(15);
  endtask

  task automatic wait_tick(input string tag);
    int t0;
    int k;
    t0 = tick_cnt;
    k  = 0;
    while (tick_cnt == t0 && k < 40) begin
      step(1);
      k++;
    end
    check(tag, 32'(tick_cnt != t0), 32'd1);
  endtask

  task automatic check_gaps(input string tag);
    foreach (gaps[i]) check(tag, 32'(gaps[i]), 32'd10);
    gaps.delete();
  endtask

  logic [3:0] tv_sw  [4] = '{4'd9, 4'd12, 4'd10, 4'd3};
  logic [3:0] tv_val [4] = '{4'd9, 4'd0,  4'd0,  4'd3};
  logic       tv_err [4] = '{1'b0, 1'b1,  1'b1,  1'b0};

  initial begin
    int t0;
    rst_n    = 1'b0;
    btn_run  = 1'b0;
    btn_load = 1'b0;
    sw_val   = 4'd0;

    // 1. reset and idle
    step(3);
    check("rst_tick", 32'(tick_o),   32'd0);
    check("rst_load", 32'(load_o),   32'd0);
    check("rst_val",  32'(load_val), 32'd0);
    check("rst_err",  32'(load_err), 32'd0);
    check("rst_run",  32'(running),  32'd0);
    rst_n = 1'b1;
    step(50);
    check("idle_ticks", 32'(tick_cnt), 32'd0);
    check("idle_run",   32'(running),  32'd0);

    // 2. held run button: one press, running, ticks every 10 cycles
    btn_run = 1'b1;
    step(20);
    check("run_held", 32'(running), 32'd1);
    btn_run = 1'b0;
    step(15);
    check("run_release", 32'(running), 32'd1);
    t0 = tick_cnt;
    step(30);
    check("run_3ticks", 32'(tick_cnt - t0), 32'd3);
    check_gaps("run_gap");

    // 3. bouncing button never settles long enough
    t0 = load_cnt;
    for (int i = 0; i < 5; i++) begin
      btn_run = 1'b1;
      step(2);
      btn_run = 1'b0;
      step(2);
    end
    step(15);
    check("bounce_run",  32'(running), 32'd1);
    check("bounce_load", 32'(load_cnt - t0), 32'd0);

    // 4. pause shortly after a tick, then resume with phase kept
    wait_tick("pre_pause");
    btn_run = 1'b1;
    step(12);
    btn_run = 1'b0;
    step(3);
    check("paused", 32'(running), 32'd0);
    t0 = tick_cnt;
    step(40);
    check("pause_ticks", 32'(tick_cnt - t0), 32'd0);
    check("pause_run",   32'(running), 32'd0);
    btn_run = 1'b1;
    step(12);
    btn_run = 1'b0;
    wait_tick("resume");
    check("resume_run", 32'(running), 32'd1);
    check_gaps("resume_gap");

    // 5. load from RUN, then preset table including out-of-range values
    sw_val = 4'd7;
    t0 = load_cnt;
    press(1'b0, 1'b1);
    check("load7_cnt",  32'(load_cnt - t0), 32'd1);
    check("load7_val",  32'(last_val), 32'd7);
    check("load7_err",  32'(last_err), 32'd0);
    check("load7_idle", 32'(running),  32'd0);
    t0 = tick_cnt;
    step(30);
    check("load7_noticks", 32'(tick_cnt - t0), 32'd0);
    check("load7_hold",    32'(load_val), 32'd7);
    for (int i = 0; i < 4; i++) begin
      sw_val = tv_sw[i];
      t0 = load_cnt;
      press(1'b0, 1'b1);
      check("tbl_cnt", 32'(load_cnt - t0), 32'd1);
      check("tbl_val", 32'(last_val), 32'(tv_val[i]));
      check("tbl_err", 32'(last_err), 32'(tv_err[i]));
      check("tbl_pulse_err", 32'(load_err), 32'd0);
    end
    gaps.delete();
    press(1'b1, 1'b0);
    wait_tick("after_load");
    check_gaps("after_load_gap");

    // 6. simultaneous presses from IDLE: load wins
    sw_val = 4'd5;
    press(1'b0, 1'b1);
    check("pre_both_val", 32'(load_val), 32'd5);
    t0 = load_cnt;
    press(1'b1, 1'b1);
    check("both_load", 32'(load_cnt - t0), 32'd1);
    check("both_run",  32'(running), 32'd0);
    check("tick_load_overlap", 32'(both_cnt), 32'd0);

    // async reset mid-RUN, then reset mid-debounce
    press(1'b1, 1'b0);
    check("pre_rst_run", 32'(running), 32'd1);
    step(3);
    rst_n = 1'b0;
    #1;
    check("arst_run",  32'(running),  32'd0);
    check("arst_val",  32'(load_val), 32'd0);
    check("arst_tick", 32'(tick_o),   32'd0);
    check("arst_load", 32'(load_o),   32'd0);
    step(3);
    rst_n = 1'b1;
    step(5);
    btn_run = 1'b1;
    step(4);
    rst_n = 1'b0;
    step(2);
    btn_run = 1'b0;
    step(1);
    rst_n = 1'b1;
    t0 = tick_cnt + load_cnt;
    step(25);
    check("abort_run",    32'(running), 32'd0);
    check("abort_events", 32'(tick_cnt + load_cnt - t0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
